// File: rtl/bit_select.sv
// Iterative rank-to-position unit: returns the bit position of the k-th matching bit
// of a word by binary descent, one tree level per cycle, with valid/ready on both sides.
module bit_select #(
    parameter  int ORDER = 3,
    localparam int W     = 1 << ORDER
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [ORDER:0]   in_rank,
    input  logic             in_zero,
    input  logic             in_top,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ORDER-1:0] out_index,
    output logic             out_found,
    output logic [ORDER:0]   out_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ORDER-1:0] HALF0     = ORDER'(W / 2);
    localparam logic [ORDER-1:0] LAST_STEP = ORDER'(ORDER - 1);

    state_t            state, state_nxt;
    logic [W-1:0]      key, key_in;
    logic [ORDER:0]    r, r_nxt, rank_q, c;
    logic [ORDER-1:0]  base, base_nxt, step, half, idx_nxt;
    logic [W-1:0]      shifted, lower;
    logic              top_q, last, found_nxt;

    function automatic logic [ORDER:0] popcnt(input logic [W-1:0] v);
        logic [ORDER:0] n;
        n = '0;
        for (int i = 0; i < W; i++) n = n + (ORDER+1)'(v[i]);
        return n;
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last      = (step == LAST_STEP);

    // Normalise every request to "find the k-th one counting from bit 0".
    always_comb begin
        key_in = '0;
        for (int i = 0; i < W; i++) begin
            key_in[i] = (in_top ? in_data[W-1-i] : in_data[i]) ^ in_zero;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        half    = HALF0 >> step;
        shifted = key >> base;
        lower   = '0;
        for (int i = 0; i < W; i++) begin
            lower[i] = shifted[i] & (i < int'(half));
        end
        c        = popcnt(lower);
        r_nxt    = r;
        base_nxt = base;
        if (r >= c) begin
            r_nxt    = r - c;
            base_nxt = base + half;
        end
        found_nxt = (rank_q < out_count);
        idx_nxt   = '0;
        if (found_nxt) idx_nxt = top_q ? ~base_nxt : base_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = SCAN;
            SCAN:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key       <= '0;
            r         <= '0;
            rank_q    <= '0;
            top_q     <= 1'b0;
            base      <= '0;
            step      <= '0;
            out_index <= '0;
            out_found <= 1'b0;
            out_count <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    key       <= key_in;
                    r         <= in_rank;
                    rank_q    <= in_rank;
                    top_q     <= in_top;
                    base      <= '0;
                    step      <= '0;
                    out_count <= popcnt(key_in);
                end
                SCAN: begin
                    r    <= r_nxt;
                    base <= base_nxt;
                    step <= step + 1'b1;
                    // The descent always runs; a missing match only masks the index.
                    if (last) begin
                        out_found <= found_nxt;
                        out_index <= idx_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_select.sv
// Self-checking bench for bit_select: directed vectors with literal expectations plus
// a scan-order select model checked on every valid output cycle.
module tb_bit_select;

    localparam int ORDER = 3;
    localparam int W     = 1 << ORDER;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_data = '0;
    logic [ORDER:0]   in_rank = '0;
    logic             in_zero = 1'b0;
    logic             in_top = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ORDER-1:0] out_index;
    logic             out_found;
    logic [ORDER:0]   out_count;

    bit_select #(.ORDER(ORDER)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_rank   (in_rank),
        .in_zero   (in_zero),
        .in_top    (in_top),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_found (out_found),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             found;
        logic [ORDER-1:0] index;
        logic [ORDER:0]   count;
    } res_t;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   rand_stall = 1'b0;
    bit   ready_force = 1'b1;
    bit   prev_valid = 1'b0;
    res_t exp_q[$];
    int   acc_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Walk the word in scan order and record where the rank-th match sits.
    function automatic res_t model(input logic [W-1:0] d, input int rank, input logic z,
                                   input logic top);
        res_t res;
        int   seen;
        int   p;
        res  = '0;
        seen = 0;
        for (int k = 0; k < W; k++) begin
            p = top ? (W - 1 - k) : k;
            if (d[p] != z) begin
                if (seen == rank) begin
                    res.found = 1'b1;
                    res.index = p[ORDER-1:0];
                end
                seen++;
            end
        end
        res.count = seen[ORDER:0];
        return res;
    endfunction

    function automatic int ctz(input logic [W-1:0] v);
        int n = 0;
        while (n < W && !v[n]) n++;
        return n;
    endfunction

    function automatic int clz(input logic [W-1:0] v);
        int n = 0;
        while (n < W && !v[W-1-n]) n++;
        return n;
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        out_ready = rand_stall ? ($urandom_range(0, 2) != 0) : ready_force;
    end

    // Scoreboard: enqueue on accept, compare on every valid cycle, pop on handoff.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            prev_valid = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_data, int'(in_rank), in_zero, in_top));
                acc_q.push_back(cyc + 1);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", int'(out_valid), 0);
                end else begin
                    check("sb_found", int'(out_found), int'(exp_q[0].found));
                    check("sb_index", int'(out_index), int'(exp_q[0].index));
                    check("sb_count", int'(out_count), int'(exp_q[0].count));
                    check("sb_in_ready_low", int'(in_ready), 0);
                    if (!prev_valid) check("sb_latency", cyc - acc_q[0], ORDER);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                    end
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic issue(input logic [W-1:0] d, input int rank, input logic z, input logic t,
                         output int acc);
        bit accepted;
        accepted = 1'b0;
        acc      = -1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        in_rank  = rank[ORDER:0];
        in_zero  = z;
        in_top   = t;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                acc      = cyc + 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_rank  = (ORDER+1)'($urandom);
        in_zero  = 1'($urandom);
        in_top   = 1'($urandom);
        if (!accepted) check("accept_timeout", int'(accepted), 1);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        if (!out_valid) check({name, "_valid_timeout"}, int'(out_valid), 1);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        if (!in_ready) check({name, "_idle_timeout"}, int'(in_ready), 1);
    endtask

    task automatic run(input logic [W-1:0] d, input int rank, input logic z, input logic t,
                       input int ef, input int ei, input int ec, input string name);
        int acc;
        issue(d, rank, z, t, acc);
        wait_valid(name);
        check({name, "_found"}, int'(out_found), ef);
        check({name, "_index"}, int'(out_index), ei);
        check({name, "_count"}, int'(out_count), ec);
        wait_idle(name);
    endtask

    initial begin
        int               a0, a1;
        logic [ORDER-1:0] held_idx;
        logic             held_found;
        logic [ORDER:0]   held_cnt;
        logic [W-1:0]     w;
        logic [W-1:0]     words[8];

        #2;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_index", int'(out_index), 0);
        check("rst_out_found", int'(out_found), 0);
        check("rst_out_count", int'(out_count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Ones from LSB and from MSB in 1011_0100.
        run(8'hB4, 0, 1'b0, 1'b0, 1, 2, 4, "lsb_r0");
        run(8'hB4, 1, 1'b0, 1'b0, 1, 4, 4, "lsb_r1");
        run(8'hB4, 2, 1'b0, 1'b0, 1, 5, 4, "lsb_r2");
        run(8'hB4, 3, 1'b0, 1'b0, 1, 7, 4, "lsb_r3");
        run(8'hB4, 4, 1'b0, 1'b0, 0, 0, 4, "lsb_r4");
        run(8'hB4, 0, 1'b0, 1'b1, 1, 7, 4, "msb_r0");
        run(8'hB4, 1, 1'b0, 1'b1, 1, 5, 4, "msb_r1");
        run(8'hB4, 2, 1'b0, 1'b1, 1, 4, 4, "msb_r2");
        run(8'hB4, 3, 1'b0, 1'b1, 1, 2, 4, "msb_r3");
        // Zeros, an all-ones word, rank = W and an out-of-range rank.
        run(8'hB4, 0, 1'b1, 1'b0, 1, 0, 4, "zero_r0");
        run(8'hB4, 1, 1'b1, 1'b0, 1, 1, 4, "zero_r1");
        run(8'hB4, 2, 1'b1, 1'b0, 1, 3, 4, "zero_r2");
        run(8'hB4, 3, 1'b1, 1'b1, 1, 0, 4, "zero_msb_r3");
        run(8'hFF, 0, 1'b1, 1'b0, 0, 0, 0, "ff_zero");
        run(8'hFF, 7, 1'b0, 1'b1, 1, 0, 8, "ff_msb_r7");
        run(8'hFF, 8, 1'b0, 1'b0, 0, 0, 8, "ff_rank_w");
        run(8'hFF, 12, 1'b0, 1'b0, 0, 0, 8, "rank_gt_w");

        // Rank 0 must agree with count-trailing / count-leading zeros.
        words = '{8'h01, 8'h80, 8'h18, 8'hF0, 8'h0A, 8'h00, 8'h40, 8'h03};
        foreach (words[i]) begin
            w = words[i];
            run(w, 0, 1'b0, 1'b0, int'(w != 0), (w != 0) ? ctz(w) : 0, $countones(w), "ctz");
            run(w, 0, 1'b0, 1'b1, int'(w != 0), (w != 0) ? (W - 1 - clz(w)) : 0,
                $countones(w), "clz");
        end

        // Hold the result under back-pressure, then hand it off.
        ready_force = 1'b0;
        issue(8'h5A, 2, 1'b0, 1'b0, a0);
        wait_valid("hold");
        held_idx   = out_index;
        held_found = out_found;
        held_cnt   = out_count;
        check("hold_index_lit", int'(held_idx), 4);
        repeat (5) begin
            @(negedge clk);
            check("hold_valid", int'(out_valid), 1);
            check("hold_in_ready", int'(in_ready), 0);
            check("hold_index", int'(out_index), int'(held_idx));
            check("hold_found", int'(out_found), int'(held_found));
            check("hold_count", int'(out_count), int'(held_cnt));
        end
        ready_force = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("handoff_valid_low", int'(out_valid), 0);
        check("handoff_in_ready", int'(in_ready), 1);
        check("handoff_index_kept", int'(out_index), int'(held_idx));
        check("handoff_count_kept", int'(out_count), int'(held_cnt));

        // Back-to-back requests: next accept comes one cycle after handoff.
        issue(8'h33, 1, 1'b0, 1'b0, a0);
        issue(8'hCC, 1, 1'b0, 1'b1, a1);
        check("b2b_spacing", a1 - a0, ORDER + 2);
        wait_valid("b2b");
        check("b2b_index", int'(out_index), 6);
        wait_idle("b2b");

        // Asynchronous reset one cycle into the scan.
        issue(8'hB4, 1, 1'b0, 1'b0, a0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_index", int'(out_index), 0);
        check("mid_rst_found", int'(out_found), 0);
        check("mid_rst_count", int'(out_count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(8'h01, 0, 1'b0, 1'b0, 1, 0, 1, "post_rst");

        // Random traffic with random consumer stalls, checked by the scoreboard.
        rand_stall = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            issue(W'($urandom), int'($urandom_range(0, W)), 1'($urandom), 1'($urandom), a0);
        end
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 0);
        rand_stall = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
